dual_issue_scheduler: RTL and testbench

DUAL_ISSUE_SCHEDULER -- requirements
Module: dual_issue_scheduler

---
 rtl/dual_issue_scheduler.sv | 141 ++++++++++++++
 tb/tb_dual_issue_scheduler.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dual_issue_scheduler.sv
// Dual-issue scheduler for an in-order RV32I pipeline.
// Each cycle it inspects the two oldest queue entries and issues zero, one or
// two of them. Slot 0 feeds the full datapath. Slot 1 feeds an ALU-only datapath.
// A one-cycle history of issued destinations interlocks dependent instructions.
module dual_issue_scheduler #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic [31:0]      inst0,
    input  logic             inst0_valid,
    input  logic [31:0]      inst1,
    input  logic             inst1_valid,
    input  logic             stall,
    input  logic             flush,
    output logic [1:0]       pop,
    output logic             issue0_valid,
    output logic [31:0]      issue0_inst,
    output logic             issue1_valid,
    output logic [31:0]      issue1_inst,
    output logic [CNT_W-1:0] pair_cnt,
    output logic [CNT_W-1:0] single_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);

    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    function automatic logic writes_rd(input logic [6:0] op);
        return op inside {OP_REG, OP_IMM, OP_LOAD, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR};
    endfunction

    function automatic logic reads_rs1(input logic [6:0] op);
        return !(op inside {OP_LUI, OP_AUIPC, OP_JAL});
    endfunction

    function automatic logic reads_rs2(input logic [6:0] op);
        return op inside {OP_REG, OP_STORE, OP_BRANCH};
    endfunction

    // Loads, stores and control transfers need the full datapath.
    function automatic logic slot0_only(input logic [6:0] op);
        return op inside {OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR};
    endfunction

    // A control transfer in slot 0 ends the issue group.
    function automatic logic ends_group(input logic [6:0] op);
        return op inside {OP_BRANCH, OP_JAL, OP_JALR};
    endfunction

    // This is the destination that can create a hazard. A value of 0 means none,
    // because x0 never carries a dependency.
    function automatic logic [4:0] hazard_rd(input logic [31:0] inst);
        return writes_rd(inst[6:0]) ? inst[11:7] : 5'd0;
    endfunction

    // This is true when the instruction reads nonzero register r.
    function automatic logic reads_reg(input logic [31:0] inst, input logic [4:0] r);
        return (r != 5'd0) &&
               ((reads_rs1(inst[6:0]) && (inst[19:15] == r)) ||
                (reads_rs2(inst[6:0]) && (inst[24:20] == r)));
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (&cnt) ? cnt : cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    logic [4:0] hist_rd0;
    logic [4:0] hist_rd1;
    logic [4:0] dst0;
    logic [4:0] dst1;
    logic       lock0;
    logic       lock1;
    logic       raw01;
    logic       waw01;
    logic       iss0;
    logic       iss1;
    logic       bubble;

    // Issue decision: interlocks against history, pairing rules, pop count.
    always_comb begin
        dst0   = hazard_rd(inst0);
        dst1   = hazard_rd(inst1);
        lock0  = reads_reg(inst0, hist_rd0) || reads_reg(inst0, hist_rd1);
        lock1  = reads_reg(inst1, hist_rd0) || reads_reg(inst1, hist_rd1);
        raw01  = reads_reg(inst1, dst0);
        waw01  = (dst0 != 5'd0) && (dst0 == dst1);
        iss0   = n_rst && inst0_valid && !lock0 && !stall && !flush;
        iss1   = iss0 && inst1_valid && !lock1 && !slot0_only(inst1[6:0]) &&
                 !ends_group(inst0[6:0]) && !raw01 && !waw01;
        bubble = n_rst && inst0_valid && !stall && !flush && lock0;
        pop    = {iss0 && iss1, iss0 ^ iss1};
    end

    // Issue registers and destination history. Flush clears them and stall freezes them.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            issue0_valid <= 1'b0;
            issue0_inst  <= '0;
            issue1_valid <= 1'b0;
            issue1_inst  <= '0;
            hist_rd0     <= '0;
            hist_rd1     <= '0;
        end else if (flush) begin
            issue0_valid <= 1'b0;
            issue0_inst  <= '0;
            issue1_valid <= 1'b0;
            issue1_inst  <= '0;
            hist_rd0     <= '0;
            hist_rd1     <= '0;
        end else if (!stall) begin
            issue0_valid <= iss0;
            issue0_inst  <= iss0 ? inst0 : '0;
            issue1_valid <= iss1;
            issue1_inst  <= iss1 ? inst1 : '0;
            hist_rd0     <= iss0 ? dst0 : '0;
            hist_rd1     <= iss1 ? dst1 : '0;
        end
    end

    // Saturating statistics. At most one counter moves per cycle.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pair_cnt   <= '0;
            single_cnt <= '0;
            bubble_cnt <= '0;
        end else begin
            if (pop == 2'd2) pair_cnt <= sat_inc(pair_cnt);
            if (pop == 2'd1) single_cnt <= sat_inc(single_cnt);
            if (bubble) bubble_cnt <= sat_inc(bubble_cnt);
        end
    end

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Testbench for dual_issue_scheduler: directed scenarios plus randomized traffic
// compared against a register-mask reference model.
module tb_dual_issue_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        n_rst;
    logic [31:0] inst0, inst1;
    logic        inst0_valid, inst1_valid, stall, flush;

    logic [1:0]  pop, s_pop;
    logic        issue0_valid, issue1_valid, s_issue0_valid, s_issue1_valid;
    logic [31:0] issue0_inst, issue1_inst, s_issue0_inst, s_issue1_inst;
    logic [15:0] pair_cnt, single_cnt, bubble_cnt;
    logic [1:0]  s_pair_cnt, s_single_cnt, s_bubble_cnt;

    dual_issue_scheduler dut (
        .clk(clk), .n_rst(n_rst),
        .inst0(inst0), .inst0_valid(inst0_valid),
        .inst1(inst1), .inst1_valid(inst1_valid),
        .stall(stall), .flush(flush), .pop(pop),
        .issue0_valid(issue0_valid), .issue0_inst(issue0_inst),
        .issue1_valid(issue1_valid), .issue1_inst(issue1_inst),
        .pair_cnt(pair_cnt), .single_cnt(single_cnt), .bubble_cnt(bubble_cnt)
    );

    dual_issue_scheduler #(.CNT_W(2)) dut_s (
        .clk(clk), .n_rst(n_rst),
        .inst0(inst0), .inst0_valid(inst0_valid),
        .inst1(inst1), .inst1_valid(inst1_valid),
        .stall(stall), .flush(flush), .pop(s_pop),
        .issue0_valid(s_issue0_valid), .issue0_inst(s_issue0_inst),
        .issue1_valid(s_issue1_valid), .issue1_inst(s_issue1_inst),
        .pair_cnt(s_pair_cnt), .single_cnt(s_single_cnt), .bubble_cnt(s_bubble_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: the set of registers written by the last issued group.
    logic [31:0] hist;
    logic        m_v0, m_v1;
    logic [31:0] m_i0, m_i1;
    int          m_pair, m_single, m_bubble;
    int          exp_pop;
    logic [1:0]  got_pop, got_s_pop;

    function automatic logic [31:0] rmask(input logic [31:0] x);
        logic [31:0] m;
        m = '0;
        if (!(x[6:0] inside {7'h37, 7'h17, 7'h6F})) m[x[19:15]] = 1'b1;
        if (x[6:0] inside {7'h33, 7'h23, 7'h63}) m[x[24:20]] = 1'b1;
        m[0] = 1'b0;
        return m;
    endfunction

    function automatic logic [31:0] wmask(input logic [31:0] x);
        logic [31:0] m;
        m = '0;
        if (x[6:0] inside {7'h33, 7'h13, 7'h03, 7'h37, 7'h17, 7'h6F, 7'h67}) m[x[11:7]] = 1'b1;
        m[0] = 1'b0;
        return m;
    endfunction

    function automatic logic slot0only(input logic [31:0] x);
        return x[6:0] inside {7'h03, 7'h23, 7'h63, 7'h6F, 7'h67};
    endfunction

    function automatic logic is_ctl(input logic [31:0] x);
        return x[6:0] inside {7'h63, 7'h6F, 7'h67};
    endfunction

    function automatic int model_pop();
        if (!inst0_valid || stall || flush || ((rmask(inst0) & hist) != 0)) return 0;
        if (inst1_valid && ((rmask(inst1) & hist) == 0) && !slot0only(inst1) && !is_ctl(inst0) &&
            ((rmask(inst1) & wmask(inst0)) == 0) && ((wmask(inst1) & wmask(inst0)) == 0))
            return 2;
        return 1;
    endfunction

    function automatic logic [15:0] sat16(input int c);
        return (c > 65535) ? 16'hFFFF : 16'(c);
    endfunction

    function automatic logic [1:0] sat2(input int c);
        return (c > 3) ? 2'd3 : 2'(c);
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [6:0] op;
        case ($urandom_range(0, 9))
            0: op = 7'h33; 1: op = 7'h13; 2: op = 7'h03; 3: op = 7'h37; 4: op = 7'h17;
            5: op = 7'h6F; 6: op = 7'h67; 7: op = 7'h23; 8: op = 7'h63; default: op = 7'h73;
        endcase
        return {7'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                3'($urandom), 5'($urandom_range(0, 3)), op};
    endfunction

    task automatic model_reset();
        hist = '0; m_v0 = 0; m_v1 = 0; m_i0 = '0; m_i1 = '0;
        m_pair = 0; m_single = 0; m_bubble = 0;
    endtask

    task automatic model_update(input int n);
        if (flush) begin
            hist = '0; m_v0 = 0; m_v1 = 0; m_i0 = '0; m_i1 = '0;
        end else if (!stall) begin
            if (n == 0 && inst0_valid && ((rmask(inst0) & hist) != 0)) m_bubble++;
            if (n == 1) m_single++;
            if (n == 2) m_pair++;
            m_v0 = (n >= 1);
            m_i0 = (n >= 1) ? inst0 : '0;
            m_v1 = (n == 2);
            m_i1 = (n == 2) ? inst1 : '0;
            hist = ((n >= 1) ? wmask(inst0) : 32'd0) | ((n == 2) ? wmask(inst1) : 32'd0);
        end
    endtask

    // Drive one cycle from posedge+1. Capture pop mid-cycle, then advance the model.
    task automatic apply(input logic [31:0] a, input logic av, input logic [31:0] b,
                         input logic bv, input logic st, input logic fl);
        inst0 = a; inst0_valid = av; inst1 = b; inst1_valid = bv; stall = st; flush = fl;
        #2;
        exp_pop   = model_pop();
        got_pop   = pop;
        got_s_pop = s_pop;
        @(posedge clk);
        #1;
        model_update(exp_pop);
    endtask

    task automatic do_reset();
        inst0 = '0; inst1 = '0; inst0_valid = 0; inst1_valid = 0; stall = 0; flush = 0;
        n_rst = 1'b0;
        #2;
        n_rst = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
    endtask

    task automatic test_reset();
        inst0 = 32'h00500093; inst1 = 32'h00700113; inst0_valid = 1; inst1_valid = 1;
        stall = 0; flush = 0; n_rst = 1'b0;
        #1;
        n_checks++; if (pop !== 2'd0) begin n_fail++; $display("FAIL reset_pop got=%0d exp=0", pop); end
        @(posedge clk); #1;
        n_checks++;
        if ({issue0_valid, issue1_valid, issue0_inst, issue1_inst} !== 66'd0) begin
            n_fail++; $display("FAIL reset_issue got v0=%b v1=%b i0=%h i1=%h exp all 0",
                               issue0_valid, issue1_valid, issue0_inst, issue1_inst);
        end
        n_checks++;
        if ({pair_cnt, single_cnt, bubble_cnt} !== 48'd0) begin
            n_fail++; $display("FAIL reset_cnt got %0d/%0d/%0d exp 0/0/0", pair_cnt, single_cnt, bubble_cnt);
        end
        do_reset();
    endtask

    task automatic test_pair();
        do_reset();
        apply(32'h00500093, 1, 32'h00700113, 1, 0, 0);
        n_checks++; if (got_pop !== 2'd2) begin n_fail++; $display("FAIL pair_pop got=%0d exp=2", got_pop); end
        n_checks++; if (issue0_inst !== 32'h00500093 || issue0_valid !== 1'b1) begin
            n_fail++; $display("FAIL pair_slot0 got v=%b i=%h exp v=1 i=00500093", issue0_valid, issue0_inst); end
        n_checks++; if (issue1_inst !== 32'h00700113 || issue1_valid !== 1'b1) begin
            n_fail++; $display("FAIL pair_slot1 got v=%b i=%h exp v=1 i=00700113", issue1_valid, issue1_inst); end
        n_checks++; if (pair_cnt !== 16'd1 || s_pair_cnt !== 2'd1) begin
            n_fail++; $display("FAIL pair_cnt got=%0d/%0d exp=1/1", pair_cnt, s_pair_cnt); end
    endtask

    task automatic test_raw_chain();
        do_reset();
        apply(32'h00500093, 1, 32'h001081B3, 1, 0, 0);
        n_checks++; if (got_pop !== 2'd1) begin n_fail++; $display("FAIL raw_pop1 got=%0d exp=1", got_pop); end
        n_checks++; if (issue1_valid !== 1'b0 || issue0_inst !== 32'h00500093) begin
            n_fail++; $display("FAIL raw_issue1 got v1=%b i0=%h exp v1=0 i0=00500093", issue1_valid, issue0_inst); end
        apply(32'h001081B3, 1, 32'h0, 0, 0, 0);
        n_checks++; if (got_pop !== 2'd0) begin n_fail++; $display("FAIL raw_pop2 got=%0d exp=0", got_pop); end
        n_checks++; if (issue0_valid !== 1'b0 || issue1_valid !== 1'b0) begin
            n_fail++; $display("FAIL raw_bubble_valid got %b%b exp 00", issue0_valid, issue1_valid); end
        n_checks++; if (bubble_cnt !== 16'd1) begin n_fail++; $display("FAIL raw_bubble_cnt got=%0d exp=1", bubble_cnt); end
        apply(32'h001081B3, 1, 32'h0, 0, 0, 0);
        n_checks++; if (got_pop !== 2'd1) begin n_fail++; $display("FAIL raw_pop3 got=%0d exp=1", got_pop); end
        n_checks++; if (issue0_inst !== 32'h001081B3 || issue0_valid !== 1'b1) begin
            n_fail++; $display("FAIL raw_issue3 got v=%b i=%h exp v=1 i=001081B3", issue0_valid, issue0_inst); end
        n_checks++; if (single_cnt !== 16'd2) begin n_fail++; $display("FAIL raw_single got=%0d exp=2", single_cnt); end
    endtask

    task automatic test_slot1_load();
        do_reset();
        apply(32'h00700113, 1, 32'h00002283, 1, 0, 0);
        n_checks++; if (got_pop !== 2'd1) begin n_fail++; $display("FAIL load_pop1 got=%0d exp=1", got_pop); end
        n_checks++; if (issue1_valid !== 1'b0) begin n_fail++; $display("FAIL load_v1 got=%b exp=0", issue1_valid); end
        apply(32'h00002283, 1, 32'h0, 0, 0, 0);
        n_checks++; if (got_pop !== 2'd1) begin n_fail++; $display("FAIL load_pop2 got=%0d exp=1", got_pop); end
        n_checks++; if (issue0_inst !== 32'h00002283) begin
            n_fail++; $display("FAIL load_slot0 got=%h exp=00002283", issue0_inst); end
    endtask

    task automatic test_stall_flush();
        do_reset();
        apply(32'h00500093, 1, 32'h00700113, 1, 0, 0);
        for (int k = 0; k < 3; k++) begin
            apply(32'h00500093, 1, 32'h00700113, 1, 1, 0);
            n_checks++; if (got_pop !== 2'd0) begin n_fail++; $display("FAIL stall_pop[%0d] got=%0d exp=0", k, got_pop); end
            n_checks++;
            if (issue0_inst !== 32'h00500093 || issue1_inst !== 32'h00700113 || !issue0_valid || !issue1_valid) begin
                n_fail++; $display("FAIL stall_hold[%0d] got %b %h %b %h exp 1 00500093 1 00700113",
                                   k, issue0_valid, issue0_inst, issue1_valid, issue1_inst);
            end
        end
        n_checks++; if (pair_cnt !== 16'd1) begin n_fail++; $display("FAIL stall_cnt got=%0d exp=1", pair_cnt); end
        apply(32'h001081B3, 1, 32'h0, 0, 1, 1);
        n_checks++; if (got_pop !== 2'd0) begin n_fail++; $display("FAIL flush_pop got=%0d exp=0", got_pop); end
        n_checks++;
        if ({issue0_valid, issue1_valid, issue0_inst, issue1_inst} !== 66'd0) begin
            n_fail++; $display("FAIL flush_clear got %b %b %h %h exp all 0", issue0_valid, issue1_valid, issue0_inst, issue1_inst);
        end
        apply(32'h001081B3, 1, 32'h0, 0, 0, 0);
        n_checks++; if (got_pop !== 2'd1) begin n_fail++; $display("FAIL flush_release got=%0d exp=1", got_pop); end
        n_checks++; if (bubble_cnt !== 16'd0) begin n_fail++; $display("FAIL flush_bubble got=%0d exp=0", bubble_cnt); end
    endtask

    task automatic test_x0_saturation();
        do_reset();
        for (int k = 0; k < 5; k++) begin
            apply(32'h00000013, 1, 32'h00000133, 1, 0, 0);
            n_checks++; if (got_pop !== 2'd2) begin n_fail++; $display("FAIL x0_pop[%0d] got=%0d exp=2", k, got_pop); end
        end
        n_checks++; if (s_pair_cnt !== 2'd3) begin n_fail++; $display("FAIL sat_pair2 got=%0d exp=3", s_pair_cnt); end
        n_checks++; if (pair_cnt !== 16'd5) begin n_fail++; $display("FAIL sat_pair16 got=%0d exp=5", pair_cnt); end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 600; k++) begin
            apply(rand_inst(), ($urandom_range(0, 3) != 0), rand_inst(), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 19) == 0));
            n_checks++; if (got_pop !== 2'(exp_pop) || got_s_pop !== 2'(exp_pop)) begin
                n_fail++; $display("FAIL rnd_pop[%0d] got=%0d/%0d exp=%0d", k, got_pop, got_s_pop, exp_pop); end
            n_checks++; if (issue0_valid !== m_v0 || issue0_inst !== m_i0 || s_issue0_inst !== m_i0) begin
                n_fail++; $display("FAIL rnd_slot0[%0d] got v=%b i=%h exp v=%b i=%h", k, issue0_valid, issue0_inst, m_v0, m_i0); end
            n_checks++; if (issue1_valid !== m_v1 || issue1_inst !== m_i1 || s_issue1_valid !== m_v1) begin
                n_fail++; $display("FAIL rnd_slot1[%0d] got v=%b i=%h exp v=%b i=%h", k, issue1_valid, issue1_inst, m_v1, m_i1); end
            n_checks++;
            if (pair_cnt !== sat16(m_pair) || single_cnt !== sat16(m_single) || bubble_cnt !== sat16(m_bubble)) begin
                n_fail++; $display("FAIL rnd_cnt16[%0d] got %0d/%0d/%0d exp %0d/%0d/%0d", k,
                                   pair_cnt, single_cnt, bubble_cnt, m_pair, m_single, m_bubble);
            end
            n_checks++;
            if (s_pair_cnt !== sat2(m_pair) || s_single_cnt !== sat2(m_single) || s_bubble_cnt !== sat2(m_bubble) ||
                s_issue0_valid !== m_v0 || s_issue1_inst !== m_i1) begin
                n_fail++; $display("FAIL rnd_cnt2[%0d] got %0d/%0d/%0d exp %0d/%0d/%0d", k,
                                   s_pair_cnt, s_single_cnt, s_bubble_cnt, sat2(m_pair), sat2(m_single), sat2(m_bubble));
            end
        end
    endtask

    task automatic test_reset_mid();
        inst0 = 32'h00500093; inst1 = 32'h00700113; inst0_valid = 1; inst1_valid = 1; stall = 0; flush = 0;
        @(posedge clk); #3;
        n_rst = 1'b0;
        #1;
        n_checks++; if (pop !== 2'd0) begin n_fail++; $display("FAIL mid_reset_pop got=%0d exp=0", pop); end
        n_checks++;
        if ({issue0_valid, issue1_valid, issue0_inst, issue1_inst} !== 66'd0) begin
            n_fail++; $display("FAIL mid_reset_issue got %b %b %h %h exp all 0", issue0_valid, issue1_valid, issue0_inst, issue1_inst);
        end
        n_checks++;
        if ({pair_cnt, single_cnt, bubble_cnt, s_pair_cnt, s_single_cnt, s_bubble_cnt} !== 54'd0) begin
            n_fail++; $display("FAIL mid_reset_cnt got %0d/%0d/%0d exp 0/0/0", pair_cnt, single_cnt, bubble_cnt);
        end
        inst0_valid = 0; inst1_valid = 0;
        n_rst = 1'b1;
        @(posedge clk); #1;
        model_reset();
        apply(32'h001081B3, 1, 32'h00700113, 1, 0, 0);
        n_checks++; if (got_pop !== 2'd2) begin n_fail++; $display("FAIL post_reset_pop got=%0d exp=2", got_pop); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_pair();
        test_raw_chain();
        test_slot1_load();
        test_stall_flush();
        test_x0_saturation();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
